// File: rtl/add7_pkg.sv
// Shared types and constants for the seven-operand add host.
// Slot order is a, b, c, d, e, f, g; slots e and g carry full 13-bit operands.
package add7_pkg;

    localparam int ARG_COUNT    = 7;
    localparam int ARG_W_NARROW = 10;
    localparam int ARG_W_WIDE   = 13;
    localparam int RES_W        = 13;
    localparam int IDX_W        = 3;

    // One bit per slot, bit i set when slot i is a wide operand (e = 4, g = 6).
    localparam logic [ARG_COUNT-1:0] SLOT_IS_WIDE = 7'b101_0000;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } add7_host_state_t;

    function automatic logic slot_is_wide(input logic [IDX_W-1:0] idx);
        logic wide;
        wide = 1'b0;
        if (idx < IDX_W'(ARG_COUNT)) begin
            wide = SLOT_IS_WIDE[idx];
        end
        return wide;
    endfunction

endpackage

// File: rtl/add7_if.sv
// Operand and result valid/ready streams between the interconnect and the add7 host.
// The slave modport is the host's view; the master modport is the interconnect's.
interface add7_if;
    import add7_pkg::*;

    logic                  s_valid;
    logic                  s_ready;
    logic [ARG_W_WIDE-1:0] s_data;

    logic                  m_valid;
    logic                  m_ready;
    logic [RES_W-1:0]      m_data;
    logic                  m_err;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_err
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_err
    );

endinterface

// File: rtl/add7_arg_bank.sv
// Seven kernel operand registers written one slot per accepted beat.
// Narrow slots keep the low ten bits and flag any truncated upper bits.
module add7_arg_bank
    import add7_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [ARG_W_WIDE-1:0]   wr_data,
    input  logic                    clr_err,
    output logic [ARG_W_NARROW-1:0] init_a,
    output logic [ARG_W_NARROW-1:0] init_b,
    output logic [ARG_W_NARROW-1:0] init_c,
    output logic [ARG_W_NARROW-1:0] init_d,
    output logic [ARG_W_WIDE-1:0]   init_e,
    output logic [ARG_W_NARROW-1:0] init_f,
    output logic [ARG_W_WIDE-1:0]   init_g,
    output logic                    width_err
);

    logic truncates;

    assign truncates = !slot_is_wide(wr_idx) &&
                       (wr_data[ARG_W_WIDE-1:ARG_W_NARROW] != '0);

    // The error flag is sticky across the whole operand set and is only
    // released once the result that reports it has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_a    <= '0;
            init_b    <= '0;
            init_c    <= '0;
            init_d    <= '0;
            init_e    <= '0;
            init_f    <= '0;
            init_g    <= '0;
            width_err <= 1'b0;
        end else begin
            if (clr_err) begin
                width_err <= 1'b0;
            end
            if (wr_en) begin
                case (wr_idx)
                    3'd0:    init_a <= wr_data[ARG_W_NARROW-1:0];
                    3'd1:    init_b <= wr_data[ARG_W_NARROW-1:0];
                    3'd2:    init_c <= wr_data[ARG_W_NARROW-1:0];
                    3'd3:    init_d <= wr_data[ARG_W_NARROW-1:0];
                    3'd4:    init_e <= wr_data;
                    3'd5:    init_f <= wr_data[ARG_W_NARROW-1:0];
                    3'd6:    init_g <= wr_data;
                    default: ;
                endcase
                if (truncates) begin
                    width_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/add7_host.sv
// Host driver for the seven-operand add kernel: gathers operands, pulses the
// kernel load, waits for done or timeout, and returns the sum downstream.
module add7_host
    import add7_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    add7_if.slave                   bus,
    output logic                    busy,
    output logic                    k_r_enable,
    output logic                    k_control,
    output logic [ARG_W_NARROW-1:0] k_init_a,
    output logic [ARG_W_NARROW-1:0] k_init_b,
    output logic [ARG_W_NARROW-1:0] k_init_c,
    output logic [ARG_W_NARROW-1:0] k_init_d,
    output logic [ARG_W_WIDE-1:0]   k_init_e,
    output logic [ARG_W_NARROW-1:0] k_init_f,
    output logic [ARG_W_WIDE-1:0]   k_init_g,
    input  logic                    k_w_enable,
    input  logic [RES_W-1:0]        k_result
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    add7_host_state_t state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             resp_done;
    logic             width_err;

    assign bus.s_ready = (state == ST_LOAD) && !rst;
    assign accept      = bus.s_valid && bus.s_ready;
    assign resp_done   = (state == ST_RESP) && bus.m_ready;
    assign busy        = !((state == ST_LOAD) && (idx == '0));
    assign k_control   = 1'b0;

    add7_arg_bank u_arg_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_idx    (idx),
        .wr_data   (bus.s_data),
        .clr_err   (resp_done),
        .init_a    (k_init_a),
        .init_b    (k_init_b),
        .init_c    (k_init_c),
        .init_d    (k_init_d),
        .init_e    (k_init_e),
        .init_f    (k_init_f),
        .init_g    (k_init_g),
        .width_err (width_err)
    );

    // A done flag in the same cycle as the timeout wins; the kernel clears
    // its done flag on the load edge, so WAIT never sees a stale one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            idx         <= '0;
            cnt         <= '0;
            k_r_enable  <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_err   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    k_r_enable <= 1'b0;
                    if (accept) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(ARG_COUNT - 1)) begin
                            state      <= ST_LAUNCH;
                            k_r_enable <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    k_r_enable <= 1'b0;
                    cnt        <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (k_w_enable) begin
                        bus.m_data  <= k_result;
                        bus.m_err   <= width_err;
                        bus.m_valid <= 1'b1;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus.m_data  <= '0;
                        bus.m_err   <= 1'b1;
                        bus.m_valid <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        idx         <= '0;
                        state       <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add7_host.sv
// Directed bench for add7_host with a behavioural stand-in for the add kernel.
// The stand-in raises its done flag eight edges after the load edge unless disabled.
module tb_add7_host;
    import add7_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                    busy;
    logic                    k_r_enable;
    logic                    k_control;
    logic [ARG_W_NARROW-1:0] k_init_a, k_init_b, k_init_c, k_init_d, k_init_f;
    logic [ARG_W_WIDE-1:0]   k_init_e, k_init_g;
    logic                    k_w_enable = 1'b0;
    logic [RES_W-1:0]        k_result = '0;

    logic       kernel_dead = 1'b0;
    logic [3:0] k_cnt = '0;

    int cyc = 0;
    int pulses = 0;
    int handshakes = 0;
    int errors = 0;
    int checks = 0;

    add7_if bus ();

    add7_host #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .busy       (busy),
        .k_r_enable (k_r_enable),
        .k_control  (k_control),
        .k_init_a   (k_init_a),
        .k_init_b   (k_init_b),
        .k_init_c   (k_init_c),
        .k_init_d   (k_init_d),
        .k_init_e   (k_init_e),
        .k_init_f   (k_init_f),
        .k_init_g   (k_init_g),
        .k_w_enable (k_w_enable),
        .k_result   (k_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (k_r_enable) pulses <= pulses + 1;
        if (bus.m_valid && bus.m_ready) handshakes <= handshakes + 1;
    end

    // Kernel stand-in: deliberately not reset, so a run abandoned by rst keeps going.
    always @(posedge clk) begin
        if (k_r_enable) begin
            k_w_enable <= 1'b0;
            k_cnt      <= 4'd8;
            k_result   <= 13'(k_init_a + k_init_b + k_init_c + k_init_d +
                              k_init_e + k_init_f + k_init_g);
        end else if (k_cnt != 4'd0) begin
            k_cnt <= k_cnt - 4'd1;
            if (k_cnt == 4'd1) k_w_enable <= !kernel_dead;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [12:0] d);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("s_ready before beat", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_ops(input logic [12:0] a, b, c, d, e, f, g);
        apply_stimulus(a);
        apply_stimulus(b);
        apply_stimulus(c);
        apply_stimulus(d);
        apply_stimulus(e);
        apply_stimulus(f);
        apply_stimulus(g);
    endtask

    task automatic wait_m_valid(input string tag);
        int n;
        n = 0;
        while (!bus.m_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(tag, 32'(bus.m_valid), 32'd1);
    endtask

    initial begin
        int t0, t1, p0, h0;
        logic seen_mv;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset s_ready", 32'(bus.s_ready), 32'd0);
        check_output("reset m_valid", 32'(bus.m_valid), 32'd0);
        check_output("reset m_data", 32'(bus.m_data), 32'd0);
        check_output("reset m_err", 32'(bus.m_err), 32'd0);
        check_output("reset k_r_enable", 32'(k_r_enable), 32'd0);
        check_output("reset k_init_g", 32'(k_init_g), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check_output("idle s_ready", 32'(bus.s_ready), 32'd1);
        check_output("k_control", 32'(k_control), 32'd0);

        // Run 1: operands 1..7, m_ready tied high.
        $display("[TB] run 1..7");
        bus.m_ready = 1'b1;
        p0 = pulses;
        h0 = handshakes;
        t0 = cyc;
        apply_stimulus(13'd1);
        check_output("busy after first beat", 32'(busy), 32'd1);
        apply_stimulus(13'd2);
        apply_stimulus(13'd3);
        apply_stimulus(13'd4);
        apply_stimulus(13'd5);
        apply_stimulus(13'd6);
        apply_stimulus(13'd7);
        check_output("launch k_r_enable", 32'(k_r_enable), 32'd1);
        check_output("k_init_e", 32'(k_init_e), 32'd5);
        check_output("k_init_g", 32'(k_init_g), 32'd7);
        wait_m_valid("run1 m_valid");
        t1 = cyc;
        check_output("run1 cycles to m_valid", 32'(t1 - t0), 32'd17);
        check_output("run1 m_data", 32'(bus.m_data), 32'd28);
        check_output("run1 m_err", 32'(bus.m_err), 32'd0);
        @(posedge clk); #1;
        check_output("run1 m_valid drop", 32'(bus.m_valid), 32'd0);
        check_output("run1 busy idle", 32'(busy), 32'd0);
        check_output("run1 load pulses", 32'(pulses - p0), 32'd1);
        check_output("run1 handshakes", 32'(handshakes - h0), 32'd1);

        // Run 2: wraps modulo 2^13.
        $display("[TB] run wide");
        send_ops(13'd1023, 13'd1023, 13'd1023, 13'd1023, 13'd8191, 13'd1023, 13'd8191);
        wait_m_valid("wide m_valid");
        check_output("wide m_data", 32'(bus.m_data), 32'd5113);
        check_output("wide m_err", 32'(bus.m_err), 32'd0);
        @(posedge clk); #1;

        // Run 3: slot a overflows its 10-bit slot, then a clean run clears the flag.
        $display("[TB] run width error");
        send_ops(13'h1405, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0);
        check_output("werr k_init_a", 32'(k_init_a), 32'd5);
        wait_m_valid("werr m_valid");
        check_output("werr m_data", 32'(bus.m_data), 32'd5);
        check_output("werr m_err", 32'(bus.m_err), 32'd1);
        @(posedge clk); #1;
        send_ops(13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7);
        wait_m_valid("clean m_valid");
        check_output("clean m_data", 32'(bus.m_data), 32'd28);
        check_output("clean m_err", 32'(bus.m_err), 32'd0);
        @(posedge clk); #1;

        // Run 4: downstream stall for 5 cycles in RESP.
        $display("[TB] run stall");
        bus.m_ready = 1'b0;
        p0 = pulses;
        h0 = handshakes;
        send_ops(13'd10, 13'd20, 13'd30, 13'd40, 13'd50, 13'd60, 13'd70);
        wait_m_valid("stall m_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("stall m_data", 32'(bus.m_data), 32'd280);
            check_output("stall s_ready", 32'(bus.s_ready), 32'd0);
            check_output("stall m_valid", 32'(bus.m_valid), 32'd1);
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        check_output("stall release m_valid", 32'(bus.m_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output("stall handshakes", 32'(handshakes - h0), 32'd1);
        check_output("stall load pulses", 32'(pulses - p0), 32'd1);

        // Run 5: kernel never finishes, 16 WAIT cycles then error result.
        $display("[TB] run timeout");
        kernel_dead = 1'b1;
        bus.m_ready = 1'b0;
        send_ops(13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7);
        t0 = cyc;
        wait_m_valid("timeout m_valid");
        t1 = cyc;
        check_output("timeout wait cycles", 32'(t1 - t0 - 1), 32'd16);
        check_output("timeout m_data", 32'(bus.m_data), 32'd0);
        check_output("timeout m_err", 32'(bus.m_err), 32'd1);
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        kernel_dead = 1'b0;

        // Run 6: reset during WAIT, then operands 2 x 7.
        $display("[TB] run reset abort");
        send_ops(13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_output("abort busy", 32'(busy), 32'd0);
        check_output("abort s_ready", 32'(bus.s_ready), 32'd1);
        seen_mv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen_mv = seen_mv | bus.m_valid;
        end
        check_output("abort no m_valid", 32'(seen_mv), 32'd0);
        send_ops(13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2, 13'd2);
        wait_m_valid("rerun m_valid");
        check_output("rerun m_data", 32'(bus.m_data), 32'd14);
        check_output("rerun m_err", 32'(bus.m_err), 32'd0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add7_host.md
# add7_host

Host-side driver for the seven-operand add kernel. Collects seven operands from an upstream valid/ready stream and launches the kernel with a one-cycle `r_enable` load pulse. Waits for the kernel's `w_enable` completion flag, then returns the 13-bit sum on a downstream valid/ready stream. It sits between the system interconnect and the synthesized kernel and owns the kernel's start/done protocol.

## Interface

- `TIMEOUT`, 64: WAIT cycles allowed before the run is abandoned (range 16..1023).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  operand beat valid.
- `s_ready`  out  1  operand beat accepted when `s_valid & s_ready`.
- `s_data`  in  13  operand value; beats arrive in order a, b, c, d, e, f, g.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed when `m_valid & m_ready`.
- `m_data`  out  13  sum.
- `m_err`  out  1  result flag: width violation or timeout.
- `busy`  out  1  high in every state except LOAD with index 0.
- `k_r_enable`  out  1  kernel load pulse.
- `k_control`  out  1  kernel `controlArr`; constant 0.
- `k_init_a`, `k_init_b`, `k_init_c`, `k_init_d`, `k_init_f`  out  10 each  kernel operands.
- `k_init_e`, `k_init_g`  out  13 each  kernel operands.
- `k_w_enable`  in  1  kernel done flag.
- `k_result`  in  13  kernel sum.

## Operation

- FSM states: LOAD, LAUNCH, WAIT, RESP.
- Reset values:
  - state LOAD, operand index 0.
  - `k_r_enable` 0, `m_valid` 0, `m_data` 0, `m_err` 0.
  - all `k_init_*` 0, width-error flag 0, timeout counter 0.
  - `s_ready` is 0 while `rst` is high.
- **LOAD**
  - `s_ready` = 1.
  - Each accepted beat writes the operand slot selected by the index, then the index increments.
  - 10-bit slots (a, b, c, d, f) keep `s_data[9:0]`. A nonzero `s_data[12:10]` sets the sticky width-error flag.
  - The 7th accepted beat (index 6) moves the FSM to LAUNCH.
- **LAUNCH**
  - Lasts exactly one cycle with `k_r_enable` = 1.
  - Next state WAIT; timeout counter cleared.
- **WAIT**
  - `k_r_enable` = 0. The counter increments every cycle.
  - `k_w_enable` sampled high: capture `k_result` into `m_data`, set `m_err` = width-error flag, set `m_valid` = 1, go to RESP.
  - Counter reaches `TIMEOUT` with no `k_w_enable`: `m_data` = 0, `m_err` = 1, `m_valid` = 1, go to RESP.
  - If `k_w_enable` and timeout happen in the same cycle, the done flag wins.
- **RESP**
  - Hold `m_valid`, `m_data` and `m_err` stable until `m_ready`.
  - On handshake: `m_valid` = 0, clear the width-error flag and the index, go to LOAD.
  - `s_ready` = 0 throughout RESP.
- `k_init_*` change only in LOAD. They stay stable from LAUNCH until the next LOAD write.
- The kernel sum is mod 2^13, so the host applies no overflow check to the result.
- `rst` mid-run: the FSM returns to LOAD at once and any partial operands are discarded. A kernel still running is ignored, and the next LAUNCH reloads it.

## Timing

- One beat per cycle accepted in LOAD; no bubbles required.
- The last operand accepted at edge T puts the FSM in LAUNCH. `k_r_enable` is high between edges T and T+1.
- The kernel clears `w_enable` on the load edge, so a stale high `w_enable` is never sampled: WAIT begins after that edge.
- With the 7-state kernel, `k_w_enable` first reads high in WAIT 8 cycles after the LAUNCH edge. `m_valid` rises on the following edge.
- Minimum throughput is one result per 7 + 1 + 8 + 1 cycles, plus downstream stall.
- Timeout counter width is clog2(TIMEOUT+1) bits.

## Structure

- Package `add7_pkg`:
  - state enum type `add7_host_state_t`;
  - `ARG_COUNT` = 7, `ARG_W_NARROW` = 10, `ARG_W_WIDE` = 13, `RES_W` = 13;
  - a per-slot width-select constant (slots e and g are wide).
- One natural sub-module, `add7_arg_bank`: seven operand registers with indexed write and the width-error detect. The FSM, counter and result register stay in `add7_host`.

## Test plan

- Operands 1..7 with `m_ready` tied high: `m_data` = 28, `m_err` = 0. `k_r_enable` is high for exactly 1 cycle. `m_valid` rises 17 cycles after the first beat is accepted.
- Operands 1023, 1023, 1023, 1023, 8191, 1023, 8191: `m_data` = 21497 mod 8192 = 5113, `m_err` = 0.
- Slot a = 0x1405, rest 0: `k_init_a` = 5, `m_data` = 5, `m_err` = 1. The next run with clean operands returns `m_err` = 0.
- Kernel stub that never raises `k_w_enable`, `TIMEOUT` = 16: `m_valid` rises after 16 WAIT cycles with `m_data` = 0 and `m_err` = 1.
- `m_ready` held low for 5 cycles in RESP: `m_data` stays stable, `s_ready` stays 0, and no second `k_r_enable` occurs. The release completes exactly one handshake.
- `rst` asserted for 1 cycle during WAIT, then operands 2 × 7: no `m_valid` for the aborted run, and the new run returns `m_data` = 14.
